icache_nway_ctrl: RTL and testbench
===================================

# icache_nway_ctrl

Parametrised N-way set-associative instruction-cache controller with internal tag/data/valid storage, tree-pLRU replacement, multi-beat line refill, whole-cache flush and access/miss performance counters. Sits between the fetch stage and the memory interconnect, replacing the direct-mapped icache controller. Read-only: the CPU never writes, so there are no dirty lines and no write-back.

## Interface
Parameters:
- ADDR_W, 32, address width.
- WAYS, 4, associativity; a power of 2, at least 2.
- SETS, 16, number of sets; a power of 2.
- LINE_WORDS, 4, 32-bit words per line; a power of 2, at least 2.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cpu_req_valid_i  in  1  fetch request.
- cpu_req_ready_o  out  1  controller accepts the request this cycle.
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] are ignored.
- cpu_rsp_valid_o  out  1  one-cycle pulse; the CPU always accepts it.
- cpu_rsp_data_o  out  32  instruction word.
- flush_i  in  1  invalidate the whole cache; sampled every cycle.
- mem_req_valid_o  out  1  line-refill request.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  ADDR_W  line-aligned refill address.
- mem_rsp_valid_i  in  1  one refill beat (one word), in ascending word order.
- mem_rsp_data_i  in  32  beat data.
- busy_o  out  1  state is not IDLE, or a flush is pending.
- acc_cnt_o  out  32  accepted requests; wraps at 2^32.
- miss_cnt_o  out  32  misses; wraps at 2^32.

## Operation
Address split, low to high:
- word offset = log2(LINE_WORDS) bits starting at bit 2;
- index = log2(SETS) bits above the word offset;
- tag = the remaining upper bits.

States:
- IDLE: cpu_req_ready_o = !flush_pend. When valid and ready are both high, register the address, increment acc_cnt, and go to LOOKUP. A pending flush has priority over requests: clear all valid bits and all pLRU bits in one cycle, clear flush_pend, stay in IDLE.
- LOOKUP: compare the tag against all ways of the indexed set.
  - Hit: pulse cpu_rsp_valid_o with the addressed word and update the pLRU toward the hit way. cpu_req_ready_o = !flush_pend. A new request accepted this cycle goes to LOOKUP, otherwise go to IDLE.
  - Miss: increment miss_cnt. Select the victim as the lowest-index invalid way, or the pLRU victim if all ways are valid. Go to REFILL_REQ.
- REFILL_REQ: mem_req_valid_o = 1 with the line-aligned address, held stable until mem_req_ready_i. Then clear the beat counter and go to REFILL.
- REFILL: on each mem_rsp_valid_i, write the beat into word[beat] of the victim way and increment the beat counter. On beat LINE_WORDS-1, write the tag, set valid, update the pLRU toward the victim way, and go to RESPOND.
- RESPOND: pulse cpu_rsp_valid_o with the requested word from the newly filled line, then go to IDLE.

Flush handling:
- flush_i high in any state sets flush_pend.
- The flush executes only in IDLE. An in-flight refill always completes and responds first.

pLRU:
- Tree of WAYS-1 bits per set. A node bit of 0 means the victim lies in the lower half.
- On an access, every node on the path to the accessed way is set to point away from it.

## Timing
- Hit latency: response 1 cycle after acceptance. Back-to-back hits sustain 1 request per cycle.
- Miss latency: 1 (LOOKUP) + request-wait cycles + LINE_WORDS beats + any beat gaps + 1 (RESPOND).
- Reset values:
  - state IDLE; all valid bits, pLRU bits, counters, beat counter and flush_pend at 0;
  - cpu_rsp_valid_o, mem_req_valid_o and busy_o at 0;
  - cpu_rsp_data_o and mem_req_addr_o at 0;
  - cpu_req_ready_o reads 1 in IDLE.
- Reset during a refill abandons it and discards the partial line. The memory side shares the same reset.
- cpu_req_ready_o is 0 in REFILL_REQ, REFILL and RESPOND.
- Beat gaps (mem_rsp_valid_i low) are legal and stall the controller with no side effect.

## Structure
- Package icache_pkg holds:
  - the state enum;
  - the localparam derivations OFF_W, IDX_W and TAG_W;
  - line and tag typedefs.
- Sub-module plru_tree, parametrised by WAYS: combinational victim selection from the set's bits, and next-bits computation for an accessed way. Storage for the bits stays in the controller.
- Tag, data and valid arrays are registers inside the controller.

## Test plan
Defaults apply: offset [3:2], index [7:4], tag [31:8].
- Cold miss, then hit:
  - After reset, request 0x100: mem_req_addr_o = 0x100, then beats 0xA0..0xA3 → response 0xA0; miss_cnt = 1.
  - Then request 0x10C → response 0xA3 the next cycle, no mem request; acc_cnt = 2.
- Replacement:
  - Miss-fill 0x000, 0x100, 0x200, 0x300 (ways 0..3), then hit 0x000.
  - Request 0x400 → evicts way 2 (0x200).
  - Then 0x000 and 0x300 hit and 0x200 misses.
- Back-to-back: requests 0x100, 0x104, 0x108 on consecutive cycles, all hits → three consecutive cpu_rsp_valid_o pulses carrying 0xA0, 0xA1, 0xA2.
- Memory stall: mem_req_ready_i low for 5 cycles with 2-cycle gaps between beats → mem_req_addr_o held stable; the response is correct after the last beat.
- Flush during refill: flush_i pulse during beat 2 → refill completes and responds; the flush then executes in IDLE. Request 0x100 misses again and cpu_req_ready_o is 0 while the flush is pending.
- Reset mid-refill: rst_ni low after beat 1 → all outputs return to reset values and counters are 0. Request 0x100 then misses.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared FSM state type and address-field widths for the
//               N-way instruction-cache controller.
// Revision    : 1.0
// ============================================================================
package icache_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int SETS_DEF       = 16;
    localparam int LINE_WORDS_DEF = 4;

    localparam int OFF_W = $clog2(LINE_WORDS_DEF);
    localparam int IDX_W = $clog2(SETS_DEF);
    localparam int TAG_W = ADDR_W_DEF - IDX_W - OFF_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOOKUP     = 3'd1,
        ST_REFILL_REQ = 3'd2,
        ST_REFILL     = 3'd3,
        ST_RESPOND    = 3'd4
    } state_e;

    typedef logic [TAG_W-1:0]                tag_t;
    typedef logic [LINE_WORDS_DEF-1:0][31:0] line_t;

endpackage
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// ============================================================================
// Module      : plru_tree
// Description : Tree-pLRU victim select and access update for one set.
//               Node n has children 2n+1 (lower half) and 2n+2 (upper half).
// Revision    : 1.0
// ============================================================================
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         i_bits,
    input  logic [$clog2(WAYS)-1:0] i_way,
    output logic [$clog2(WAYS)-1:0] o_victim,
    output logic [WAYS-2:0]         o_next_bits
);
    localparam int c_lvls = $clog2(WAYS);

    always_comb begin
        int node_v;
        o_victim = '0;
        node_v   = 0;
        for (int l = 0; l < c_lvls; l++) begin
            o_victim[c_lvls-1-l] = i_bits[node_v];
            node_v = 2 * node_v + 1 + int'(i_bits[node_v]);
        end
    end

    // Every node on the path is pointed at the half not containing i_way.
    always_comb begin
        int node_u;
        o_next_bits = i_bits;
        node_u      = 0;
        for (int l = 0; l < c_lvls; l++) begin
            o_next_bits[node_u] = ~i_way[c_lvls-1-l];
            node_u = 2 * node_u + 1 + int'(i_way[c_lvls-1-l]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_nway_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_nway_ctrl
// Description : N-way set-associative read-only instruction-cache controller
//               with tree-pLRU replacement, multi-beat refill and flush.
// Revision    : 1.0
// ============================================================================
module icache_nway_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_valid_i,
    output logic              cpu_req_ready_o,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_rsp_valid_o,
    output logic [31:0]       cpu_rsp_data_o,
    input  logic              flush_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [31:0]       mem_rsp_data_i,
    output logic              busy_o,
    output logic [31:0]       acc_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int c_off_w = $clog2(LINE_WORDS);
    localparam int c_idx_w = $clog2(SETS);
    localparam int c_tag_w = ADDR_W - c_idx_w - c_off_w - 2;
    localparam int c_way_w = $clog2(WAYS);

    state_e              r_state, w_state_nxt;
    logic [ADDR_W-1:2]   r_addr;
    logic [c_way_w-1:0]  r_victim;
    logic [c_off_w-1:0]  r_beat;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-2:0]     r_plru  [SETS];
    logic [c_tag_w-1:0]  r_tag   [WAYS][SETS];
    logic [31:0]         r_data  [WAYS][SETS][LINE_WORDS];
    logic                r_flush_pend;
    logic [31:0]         r_acc_cnt, r_miss_cnt;

    logic [c_off_w-1:0]  w_off;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_tag_w-1:0]  w_tag;
    logic [WAYS-1:0]     w_hit_vec;
    logic                w_hit;
    logic [c_way_w-1:0]  w_hit_way, w_free_way, w_alloc_way, w_plru_victim;
    logic [c_way_w-1:0]  w_touch_way, w_rsp_way;
    logic [WAYS-2:0]     w_plru_next;
    logic                w_accept, w_lookup_hit, w_miss, w_flush_do;
    logic                w_beat_wr, w_fill_done;

    assign w_off = r_addr[2 +: c_off_w];
    assign w_idx = r_addr[2 + c_off_w +: c_idx_w];
    assign w_tag = r_addr[ADDR_W-1 -: c_tag_w];

    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) w_hit_way = c_way_w'(w);
        end
        w_hit = |w_hit_vec;
    end

    // Invalid ways are filled lowest-index first; pLRU only once the set is full.
    always_comb begin
        w_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_free_way = c_way_w'(w);
        end
        w_alloc_way = (&r_valid[w_idx]) ? w_plru_victim : w_free_way;
    end

    assign w_touch_way = (r_state == ST_REFILL) ? r_victim : w_hit_way;

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru (
        .i_bits      (r_plru[w_idx]),
        .i_way       (w_touch_way),
        .o_victim    (w_plru_victim),
        .o_next_bits (w_plru_next)
    );

    always_comb begin
        w_state_nxt     = r_state;
        cpu_req_ready_o = 1'b0;
        cpu_rsp_valid_o = 1'b0;
        mem_req_valid_o = 1'b0;
        w_accept        = 1'b0;
        w_lookup_hit    = 1'b0;
        w_miss          = 1'b0;
        w_flush_do      = 1'b0;
        w_beat_wr       = 1'b0;
        w_fill_done     = 1'b0;
        w_rsp_way       = r_victim;
        case (r_state)
            ST_IDLE: begin
                cpu_req_ready_o = !r_flush_pend;
                if (r_flush_pend) begin
                    w_flush_do = 1'b1;
                end else if (cpu_req_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    cpu_rsp_valid_o = 1'b1;
                    w_lookup_hit    = 1'b1;
                    w_rsp_way       = w_hit_way;
                    cpu_req_ready_o = !r_flush_pend;
                    if (!r_flush_pend && cpu_req_valid_i) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_LOOKUP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_miss      = 1'b1;
                    w_state_nxt = ST_REFILL_REQ;
                end
            end
            ST_REFILL_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) w_state_nxt = ST_REFILL;
            end
            ST_REFILL: begin
                if (mem_rsp_valid_i) begin
                    w_beat_wr = 1'b1;
                    if (r_beat == c_off_w'(LINE_WORDS - 1)) begin
                        w_fill_done = 1'b1;
                        w_state_nxt = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                cpu_rsp_valid_o = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        cpu_rsp_data_o = cpu_rsp_valid_o ? r_data[w_rsp_way][w_idx][w_off] : 32'd0;
    end

    assign mem_req_addr_o = {r_addr[ADDR_W-1:2+c_off_w], {(c_off_w + 2){1'b0}}};
    assign busy_o         = (r_state != ST_IDLE) || r_flush_pend;
    assign acc_cnt_o      = r_acc_cnt;
    assign miss_cnt_o     = r_miss_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= '0;
            r_victim     <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_acc_cnt    <= '0;
            r_miss_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            if (w_accept) begin
                r_addr    <= cpu_addr_i[ADDR_W-1:2];
                r_acc_cnt <= r_acc_cnt + 32'd1;
            end
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
                r_victim   <= w_alloc_way;
            end
            if (mem_req_valid_o && mem_req_ready_i) r_beat <= '0;
            if (w_beat_wr) r_beat <= r_beat + 1'b1;
            if (w_lookup_hit) r_plru[w_idx] <= w_plru_next;
            if (w_fill_done) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_plru[w_idx]            <= w_plru_next;
            end
            if (w_flush_do) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[s] <= '0;
                    r_plru[s]  <= '0;
                end
            end
            // A flush arriving in the same cycle as the one being executed stays pending.
            if (flush_i)         r_flush_pend <= 1'b1;
            else if (w_flush_do) r_flush_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_beat_wr) begin
            r_data[r_victim][w_idx][r_beat] <= mem_rsp_data_i;
            if (w_fill_done) r_tag[r_victim][w_idx] <= w_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_nway_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_nway_ctrl
// Description : Directed plus randomized bench for icache_nway_ctrl against a
//               set/way/tree reference model of the default configuration.
// Revision    : 1.0
// ============================================================================
module tb_icache_nway_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        cpu_req_valid_i = 1'b0;
    logic        cpu_req_ready_o;
    logic [31:0] cpu_addr_i = '0;
    logic        cpu_rsp_valid_o;
    logic [31:0] cpu_rsp_data_o;
    logic        flush_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;
    logic        busy_o;
    logic [31:0] acc_cnt_o, miss_cnt_o;

    int n_pass = 0;
    int n_total = 0;

    bit          m_valid [16][4];
    logic [23:0] m_tag   [16][4];
    bit          m_tree  [16][3];
    int          m_acc, m_miss;

    always #5 clk = ~clk;

    icache_nway_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .cpu_req_valid_i (cpu_req_valid_i),
        .cpu_req_ready_o (cpu_req_ready_o),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_rsp_valid_o (cpu_rsp_valid_o),
        .cpu_rsp_data_o  (cpu_rsp_data_o),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .busy_o          (busy_o),
        .acc_cnt_o       (acc_cnt_o),
        .miss_cnt_o      (miss_cnt_o)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if ((a >> 4) == 32'h10) return 32'hA0 + ((a >> 2) & 32'h3);
        return 32'h5EED_0000 ^ {a[31:2], 2'b00};
    endfunction

    function automatic int m_find(input logic [31:0] a);
        int s = int'((a >> 4) & 32'hF);
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:8]) return w;
        return -1;
    endfunction

    task automatic m_touch(input int s, input int w);
        int node = 0, lo = 0, span = 4;
        while (span > 1) begin
            int half = span / 2;
            bit up = (w >= lo + half);
            m_tree[s][node] = !up;
            node = 2 * node + 1 + (up ? 1 : 0);
            if (up) lo += half;
            span = half;
        end
    endtask

    function automatic int m_victim(input int s);
        int node = 0, lo = 0, span = 4;
        for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
        while (span > 1) begin
            int half = span / 2;
            if (m_tree[s][node]) begin lo += half; node = 2 * node + 2; end
            else node = 2 * node + 1;
            span = half;
        end
        return lo;
    endfunction

    task automatic m_flush();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
            for (int n = 0; n < 3; n++) m_tree[s][n] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_ctrl", {cpu_rsp_valid_o, mem_req_valid_o, busy_o, cpu_req_ready_o}, 4'b0001);
        chk("rst_data", {cpu_rsp_data_o, mem_req_addr_o}, 64'd0);
        chk("rst_cnts", {acc_cnt_o, miss_cnt_o}, 64'd0);
    endtask

    task automatic apply_reset();
        cpu_req_valid_i = 0; mem_req_ready_i = 0; mem_rsp_valid_i = 0; flush_i = 0;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs();
        tick(); tick();
        rst_ni = 1'b1;
        m_flush(); m_acc = 0; m_miss = 0;
    endtask

    // One request end to end; flush_beat/reset_beat < 0 disable those events.
    task automatic do_req(input logic [31:0] addr, input int rdy_delay, input int gap_lo,
                          input int gap_hi, input int flush_beat, input int reset_beat);
        int cnt, s, way;
        bit exp_hit, stable;
        logic [31:0] line;
        line = addr & ~32'hF;
        s    = int'((addr >> 4) & 32'hF);
        cnt  = 0;
        while (!cpu_req_ready_o && cnt < 50) begin tick(); cnt++; end
        chk("req_ready_wait", cpu_req_ready_o, 1'b1);
        way = m_find(addr);
        exp_hit = (way >= 0);
        cpu_req_valid_i = 1'b1; cpu_addr_i = addr;
        tick();
        cpu_req_valid_i = 1'b0;
        m_acc++;
        chk("hit_pulse", cpu_rsp_valid_o, exp_hit);
        if (exp_hit) begin
            chk("hit_data", cpu_rsp_data_o, mem_word(addr));
            m_touch(s, way);
            chk("cnts_hit", {acc_cnt_o, miss_cnt_o}, {32'(m_acc), 32'(m_miss)});
            return;
        end
        m_miss++;
        way = m_victim(s);
        cnt = 0;
        while (!mem_req_valid_o && cnt < 20) begin tick(); cnt++; end
        chk("memreq_seen", mem_req_valid_o, 1'b1);
        chk("memreq_addr", mem_req_addr_o, line);
        chk("refill_rdy_busy", {cpu_req_ready_o, busy_o}, 2'b01);
        stable = 1'b1;
        repeat (rdy_delay) begin
            tick();
            if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== line) stable = 1'b0;
        end
        chk("memreq_stable", stable, 1'b1);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(gap_hi, gap_lo)) tick();
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(line + 32'(4 * b));
            flush_i         = (b == flush_beat);
            tick();
            mem_rsp_valid_i = 1'b0;
            flush_i         = 1'b0;
            if (b == reset_beat) begin
                rst_ni = 1'b0;
                #1;
                check_reset_outputs();
                tick();
                rst_ni = 1'b1;
                m_flush(); m_acc = 0; m_miss = 0;
                return;
            end
        end
        chk("miss_rsp_valid", cpu_rsp_valid_o, 1'b1);
        chk("miss_rsp_data", cpu_rsp_data_o, mem_word(addr));
        m_valid[s][way] = 1'b1;
        m_tag[s][way]   = addr[31:8];
        m_touch(s, way);
        chk("cnts_miss", {acc_cnt_o, miss_cnt_o}, {32'(m_acc), 32'(m_miss)});
        if (flush_beat >= 0 && flush_beat < 4) begin
            tick();
            chk("flush_pend_rdy_busy", {cpu_req_ready_o, busy_o}, 2'b01);
            tick();
            chk("flush_done_rdy_busy", {cpu_req_ready_o, busy_o}, 2'b10);
            m_flush();
        end
    endtask

    initial begin
        m_flush(); m_acc = 0; m_miss = 0;
        #2;
        apply_reset();

        // Cold miss then hit in the same line.
        do_req(32'h100, 0, 0, 0, -1, -1);
        chk("cold_miss_cnt", miss_cnt_o, 32'd1);
        do_req(32'h10C, 0, 0, 0, -1, -1);
        chk("hit_acc_cnt", acc_cnt_o, 32'd2);

        // Replacement: fill ways 0..3, touch way 0, 0x400 must evict 0x200.
        apply_reset();
        do_req(32'h000, 0, 0, 0, -1, -1);
        do_req(32'h100, 0, 0, 0, -1, -1);
        do_req(32'h200, 0, 0, 0, -1, -1);
        do_req(32'h300, 0, 0, 0, -1, -1);
        do_req(32'h000, 0, 0, 0, -1, -1);
        do_req(32'h400, 0, 0, 0, -1, -1);
        do_req(32'h000, 0, 0, 0, -1, -1);
        do_req(32'h300, 0, 0, 0, -1, -1);
        do_req(32'h200, 0, 0, 0, -1, -1);
        chk("repl_miss_cnt", miss_cnt_o, 32'd6);

        // Back-to-back hits on line 0x100.
        do_req(32'h100, 0, 0, 0, -1, -1);
        while (!cpu_req_ready_o) tick();
        cpu_req_valid_i = 1'b1; cpu_addr_i = 32'h100;
        tick();
        chk("b2b_0", {cpu_rsp_valid_o, cpu_rsp_data_o}, {1'b1, 32'hA0});
        cpu_addr_i = 32'h104;
        tick();
        chk("b2b_1", {cpu_rsp_valid_o, cpu_rsp_data_o}, {1'b1, 32'hA1});
        cpu_addr_i = 32'h108;
        tick();
        chk("b2b_2", {cpu_rsp_valid_o, cpu_rsp_data_o}, {1'b1, 32'hA2});
        cpu_req_valid_i = 1'b0;
        m_acc += 3;
        m_touch(0, m_find(32'h100));
        chk("b2b_acc", acc_cnt_o, 32'(m_acc));
        tick();

        // Memory stall with fixed 2-cycle beat gaps.
        do_req(32'h540, 5, 2, 2, -1, -1);

        // Flush during beat 2, then 0x100 must miss again.
        do_req(32'h600, 1, 0, 1, 2, -1);
        do_req(32'h100, 0, 0, 0, -1, -1);
        chk("post_flush_miss", miss_cnt_o, 32'(m_miss));

        // Reset after beat 1, then 0x100 misses with counters from zero.
        do_req(32'h700, 0, 0, 1, -1, 1);
        do_req(32'h100, 0, 0, 0, -1, -1);
        chk("post_reset_cnts", {acc_cnt_o, miss_cnt_o}, {32'd1, 32'd1});

        // Randomized traffic over a small address pool to mix hits and misses.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(7, 0)) << 8) | (32'($urandom_range(3, 0)) << 4) |
                32'($urandom_range(15, 0));
            do_req(a, $urandom_range(3, 0), 0, $urandom_range(2, 0),
                   ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 0)) : -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
